// File: rtl/cpuy_fetch_seq_pkg.sv
// Shared types and constants for the cpuy fetch sequencer.
package cpuy_pkg;

  typedef enum logic [1:0] {
    FETCH_OP   = 2'd0,
    FETCH_OPND = 2'd1,
    ISSUE      = 2'd2,
    IRQ_ENTRY  = 2'd3
  } state_e;

  // The operand count lives in the top OPCNT_W bits of the opcode byte.
  localparam int OPCNT_W = 2;

  localparam logic [11:0] DEF_RESET_VECTOR  = 12'h000;
  localparam logic [11:0] DEF_VECTOR_BASE   = 12'h010;
  localparam logic [11:0] DEF_VECTOR_STRIDE = 12'h010;

endpackage

// File: rtl/cpuy_fetch_seq_if.sv
// ROM bus and execute-stage handshake between the fetch sequencer and its neighbours.
interface cpuy_fetch_seq_if #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int MAX_OPERANDS = 3
);
  logic [ADDR_W-1:0]              addr_bus;
  logic [DATA_W-1:0]              data_bus;
  logic                           instr_valid;
  logic                           instr_ready;
  logic [DATA_W-1:0]              opcode;
  logic [MAX_OPERANDS*DATA_W-1:0] operands;
  logic [1:0]                     operand_count;
  logic                           branch_valid;
  logic [ADDR_W-1:0]              branch_target;
  logic                           irq_done;

  modport master (
    output addr_bus, instr_valid, opcode, operands, operand_count,
    input  data_bus, instr_ready, branch_valid, branch_target, irq_done
  );

  modport slave (
    input  addr_bus, instr_valid, opcode, operands, operand_count,
    output data_bus, instr_ready, branch_valid, branch_target, irq_done
  );
endinterface

// File: rtl/cpuy_irq_arbiter.sv
// Combinational lowest-index-wins priority encoder over the interrupt channels.
module cpuy_irq_arbiter
  import cpuy_pkg::*;
#(
  parameter int NUM_IRQ = 3,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               vld,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_IRQ-1:0] grant
);

  // Scan downwards so the lowest set bit is the last (winning) assignment.
  always_comb begin
    vld   = 1'b0;
    idx   = '0;
    grant = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld      = 1'b1;
        idx      = IDX_W'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpuy_fetch_seq.sv
// Instruction-fetch sequencer: owns the pc, gathers opcode plus operand bytes
// from ROM, issues them over valid/ready, and handles vectored interrupt entry.
module cpuy_fetch_seq
  import cpuy_pkg::*;
#(
  parameter int              ADDR_W        = 12,
  parameter int              DATA_W        = 8,
  parameter int              MAX_OPERANDS  = 3,
  parameter int              NUM_IRQ       = 3,
  parameter logic [ADDR_W-1:0] RESET_VECTOR  = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(DEF_VECTOR_BASE),
  parameter logic [ADDR_W-1:0] VECTOR_STRIDE = ADDR_W'(DEF_VECTOR_STRIDE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               gie,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               irq_active,
  output logic [ADDR_W-1:0]  ret_pc,
  cpuy_fetch_seq_if.master   bus
);

  localparam int         IRQ_IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [1:0] MAX_CNT   = 2'(MAX_OPERANDS);

  state_e                                state_q, state_d;
  logic [ADDR_W-1:0]                     pc_q, pc_d;
  logic [DATA_W-1:0]                     opcode_q, opcode_d;
  logic [MAX_OPERANDS-1:0][DATA_W-1:0]   operands_q, operands_d;
  logic [1:0]                            cnt_q, cnt_d;
  logic [1:0]                            idx_q, idx_d;
  logic [ADDR_W-1:0]                     ret_pc_q, ret_pc_d;
  logic [NUM_IRQ-1:0]                    irq_ack_q, irq_ack_d;
  logic                                  irq_active_q, irq_active_d;
  logic                                  instr_valid_q, instr_valid_d;

  logic                 arb_vld;
  logic [IRQ_IDX_W-1:0] arb_idx;
  logic [NUM_IRQ-1:0]   arb_grant;
  logic                 pending;
  logic [OPCNT_W-1:0]   cnt_field;
  logic [1:0]           fetch_cnt;
  logic [ADDR_W-1:0]    irq_vector;

  cpuy_irq_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IRQ_IDX_W)
  ) u_arb (
    .req   (irq_req & irq_en),
    .vld   (arb_vld),
    .idx   (arb_idx),
    .grant (arb_grant)
  );

  assign pending    = gie & arb_vld & ~irq_active_q;
  assign cnt_field  = bus.data_bus[DATA_W-1 -: OPCNT_W];
  assign fetch_cnt  = (cnt_field > MAX_CNT) ? MAX_CNT : cnt_field;
  assign irq_vector = VECTOR_BASE + ADDR_W'(arb_idx) * VECTOR_STRIDE;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    opcode_d      = opcode_q;
    operands_d    = operands_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    ret_pc_d      = ret_pc_q;
    irq_ack_d     = '0;
    irq_active_d  = irq_active_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      FETCH_OP: begin
        if (!stall) begin
          // An interrupt leaves the opcode byte unconsumed so it is refetched on return.
          if (pending) begin
            state_d = IRQ_ENTRY;
          end else begin
            opcode_d = bus.data_bus;
            pc_d     = pc_q + ADDR_W'(1);
            cnt_d    = fetch_cnt;
            idx_d    = 2'd0;
            if (fetch_cnt == 2'd0) begin
              state_d       = ISSUE;
              instr_valid_d = 1'b1;
            end else begin
              state_d = FETCH_OPND;
            end
          end
        end
      end

      FETCH_OPND: begin
        if (!stall) begin
          for (int k = 0; k < MAX_OPERANDS; k++) begin
            if (idx_q == 2'(k)) operands_d[k] = bus.data_bus;
          end
          pc_d  = pc_q + ADDR_W'(1);
          idx_d = idx_q + 2'd1;
          if (idx_q == cnt_q - 2'd1) begin
            state_d       = ISSUE;
            instr_valid_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH_OP;
          if (bus.irq_done) begin
            pc_d         = ret_pc_q;
            irq_active_d = 1'b0;
          end else if (bus.branch_valid) begin
            pc_d = bus.branch_target;
          end
        end
      end

      IRQ_ENTRY: begin
        state_d = FETCH_OP;
        if (arb_vld) begin
          ret_pc_d     = pc_q;
          pc_d         = irq_vector;
          irq_ack_d    = arb_grant;
          irq_active_d = 1'b1;
        end
      end

      default: state_d = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_OP;
      pc_q          <= RESET_VECTOR;
      opcode_q      <= '0;
      operands_q    <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      ret_pc_q      <= '0;
      irq_ack_q     <= '0;
      irq_active_q  <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      opcode_q      <= opcode_d;
      operands_q    <= operands_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      ret_pc_q      <= ret_pc_d;
      irq_ack_q     <= irq_ack_d;
      irq_active_q  <= irq_active_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.addr_bus      = pc_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.opcode        = opcode_q;
  assign bus.operands      = operands_q;
  assign bus.operand_count = cnt_q;
  assign irq_ack           = irq_ack_q;
  assign irq_active        = irq_active_q;
  assign ret_pc            = ret_pc_q;

endmodule

// File: tb/tb_cpuy_fetch_seq.sv
// Self-checking bench for cpuy_fetch_seq: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_cpuy_fetch_seq;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [2:0] irq_req;
  logic [2:0] irq_en;
  logic       gie;
  logic [2:0] irq_ack;
  logic       irq_active;
  logic [11:0] ret_pc;
  logic [7:0] rom [4096];

  int n_tests;
  int n_fail;

  cpuy_fetch_seq_if #(.ADDR_W(12), .DATA_W(8), .MAX_OPERANDS(3)) bus ();

  assign bus.data_bus = rom[bus.addr_bus];

  cpuy_fetch_seq dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .irq_req    (irq_req),
    .irq_en     (irq_en),
    .gie        (gie),
    .irq_ack    (irq_ack),
    .irq_active (irq_active),
    .ret_pc     (ret_pc),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; irq_req = 0; irq_en = 0; gie = 0;
    bus.instr_ready = 0; bus.branch_valid = 0; bus.branch_target = 0; bus.irq_done = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    clear_rom();
    rom[0] = 8'hC3;
    rst = 1;
    tick();
    tick();
    n_tests++; if (bus.addr_bus !== 12'h000) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", bus.addr_bus); end
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.instr_valid); end
    n_tests++; if (irq_ack !== 3'b000 || irq_active !== 1'b0) begin n_fail++; $display("FAIL reset_irq: ack %0b active %0b expected 0/0", irq_ack, irq_active); end
    n_tests++; if (bus.opcode !== 8'h00 || bus.operands !== 24'h0 || bus.operand_count !== 2'd0 || ret_pc !== 12'h0) begin
      n_fail++; $display("FAIL reset_data: opcode %0h operands %0h count %0d ret_pc %0h expected all 0", bus.opcode, bus.operands, bus.operand_count, ret_pc);
    end
    rst = 0;
  endtask

  task automatic test_single();
    clear_inputs();
    clear_rom();
    rom[0] = 8'h05;
    bus.instr_ready = 1;
    do_reset();
    n_tests++; if (bus.addr_bus !== 12'h000) begin n_fail++; $display("FAIL single_addr0: got %0h expected 0", bus.addr_bus); end
    tick();
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 8'h05 || bus.operand_count !== 2'd0) begin
      n_fail++; $display("FAIL single_issue: valid %0b opcode %0h count %0d expected 1/05/0", bus.instr_valid, bus.opcode, bus.operand_count);
    end
    n_tests++; if (bus.addr_bus !== 12'h001) begin n_fail++; $display("FAIL single_addr1: got %0h expected 1", bus.addr_bus); end
    tick();
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: valid %0b expected 0", bus.instr_valid); end
    tick();
    n_tests++; if (bus.addr_bus !== 12'h002) begin n_fail++; $display("FAIL single_addr2: got %0h expected 2", bus.addr_bus); end
  endtask

  task automatic test_operands_backpressure();
    int cyc;
    clear_inputs();
    clear_rom();
    rom[0] = 8'hC3; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h33;
    do_reset();
    cyc = 0;
    while (bus.instr_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL opnd_latency: got %0d cycles expected 4", cyc); end
    n_tests++; if (bus.opcode !== 8'hC3 || bus.operands !== 24'h332211 || bus.operand_count !== 2'd3) begin
      n_fail++; $display("FAIL opnd_values: opcode %0h operands %0h count %0d expected C3/332211/3", bus.opcode, bus.operands, bus.operand_count);
    end
    n_tests++; if (bus.addr_bus !== 12'h004) begin n_fail++; $display("FAIL opnd_pc: got %0h expected 4", bus.addr_bus); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 8'hC3 || bus.operands !== 24'h332211 || bus.addr_bus !== 12'h004) begin
        n_fail++; $display("FAIL opnd_hold%0d: valid %0b opcode %0h operands %0h pc %0h", i, bus.instr_valid, bus.opcode, bus.operands, bus.addr_bus);
      end
    end
    bus.instr_ready = 1;
    tick();
    bus.instr_ready = 0;
    n_tests++; if (bus.instr_valid !== 1'b0 || bus.addr_bus !== 12'h004) begin
      n_fail++; $display("FAIL opnd_accept: valid %0b pc %0h expected 0/4", bus.instr_valid, bus.addr_bus);
    end
  endtask

  task automatic test_irq();
    int cyc;
    clear_inputs();
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h03;
    rom[4] = 8'h80; rom[5] = 8'h04; rom[6] = 8'h05; rom[7] = 8'h00;
    rom[12'h020] = 8'h00;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      cyc = 0;
      while (bus.instr_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
      n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL irq_wait%0d: valid %0b expected 1", n, bus.instr_valid); end
      if (n == 1) begin irq_en = 3'b110; irq_req = 3'b110; gie = 1; end
      bus.instr_ready = 1;
      tick();
      bus.instr_ready = 0;
    end
    n_tests++; if (bus.addr_bus !== 12'h007) begin n_fail++; $display("FAIL irq_boundary_pc: got %0h expected 7", bus.addr_bus); end
    tick();
    n_tests++; if (irq_ack !== 3'b000 || bus.addr_bus !== 12'h007) begin n_fail++; $display("FAIL irq_entry_hold: ack %0b pc %0h expected 0/7", irq_ack, bus.addr_bus); end
    tick();
    n_tests++; if (irq_ack !== 3'b010 || bus.addr_bus !== 12'h020 || ret_pc !== 12'h007 || irq_active !== 1'b1) begin
      n_fail++; $display("FAIL irq_entry: ack %0b pc %0h ret_pc %0h active %0b expected 010/020/007/1", irq_ack, bus.addr_bus, ret_pc, irq_active);
    end
    irq_req = 3'b100;
    tick();
    n_tests++; if (irq_ack !== 3'b000 || irq_active !== 1'b1 || bus.instr_valid !== 1'b1 || bus.addr_bus !== 12'h021) begin
      n_fail++; $display("FAIL irq_masked: ack %0b active %0b valid %0b pc %0h expected 0/1/1/021", irq_ack, irq_active, bus.instr_valid, bus.addr_bus);
    end
    irq_req = 3'b000;
    bus.irq_done = 1; bus.branch_valid = 1; bus.branch_target = 12'h100; bus.instr_ready = 1;
    tick();
    bus.irq_done = 0; bus.branch_valid = 0; bus.instr_ready = 0;
    n_tests++; if (bus.addr_bus !== 12'h007 || irq_active !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL irq_return: pc %0h active %0b valid %0b expected 007/0/0", bus.addr_bus, irq_active, bus.instr_valid);
    end
    tick();
    n_tests++; if (bus.addr_bus !== 12'h008 || irq_ack !== 3'b000) begin
      n_fail++; $display("FAIL irq_resume: pc %0h ack %0b expected 008/0", bus.addr_bus, irq_ack);
    end
    clear_inputs();
  endtask

  task automatic test_wrap_and_abort();
    int cyc;
    clear_inputs();
    clear_rom();
    rom[12'h000] = 8'h05;
    rom[12'h001] = 8'h66;
    rom[12'hFFF] = 8'h40;
    do_reset();
    cyc = 0;
    while (bus.instr_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    bus.branch_valid = 1; bus.branch_target = 12'hFFF; bus.instr_ready = 1;
    tick();
    bus.branch_valid = 0; bus.instr_ready = 0;
    n_tests++; if (bus.addr_bus !== 12'hFFF) begin n_fail++; $display("FAIL wrap_branch: pc %0h expected FFF", bus.addr_bus); end
    tick();
    n_tests++; if (bus.addr_bus !== 12'h000 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pc0: pc %0h valid %0b expected 000/0", bus.addr_bus, bus.instr_valid);
    end
    tick();
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 8'h40 || bus.operand_count !== 2'd1 || bus.operands !== 24'h000005 || bus.addr_bus !== 12'h001) begin
      n_fail++; $display("FAIL wrap_issue: valid %0b opcode %0h count %0d operands %0h pc %0h expected 1/40/1/000005/001",
                          bus.instr_valid, bus.opcode, bus.operand_count, bus.operands, bus.addr_bus);
    end
    rom[12'hFFF] = 8'hC0;
    bus.branch_valid = 1; bus.branch_target = 12'hFFF; bus.instr_ready = 1;
    tick();
    bus.branch_valid = 0; bus.instr_ready = 0;
    tick(); tick(); tick();
    n_tests++; if (bus.addr_bus !== 12'h002 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_midway: pc %0h valid %0b expected 002/0", bus.addr_bus, bus.instr_valid);
    end
    rst = 1;
    tick();
    rst = 0;
    n_tests++; if (bus.addr_bus !== 12'h000 || bus.instr_valid !== 1'b0 || irq_active !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset: pc %0h valid %0b active %0b expected 000/0/0", bus.addr_bus, bus.instr_valid, irq_active);
    end
  endtask

  // Instruction-level model: each accepted instruction advances pc by 1+cnt
  // bytes, then redirects/interrupt entry are applied at the boundary.
  task automatic test_random();
    logic [11:0] m_pc, m_ret, m_next, tgt;
    logic [7:0]  m_ops [3];
    logic [7:0]  op;
    logic [2:0]  exp_ack, m_req, m_en;
    logic        m_active, m_gie, br, done;
    int          cnt, cyc, k;
    clear_inputs();
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
    do_reset();
    m_pc = 12'h000; m_ret = 12'h000; m_active = 0; exp_ack = 3'b000;
    for (int i = 0; i < 3; i++) m_ops[i] = 8'h00;
    for (int n = 0; n < 80; n++) begin
      op  = rom[m_pc];
      cnt = int'(op) / 64;
      for (int i = 0; i < cnt; i++) m_ops[i] = rom[m_pc + 12'(1 + i)];
      m_next = m_pc + 12'(1 + cnt);
      cyc = 0;
      while (bus.instr_valid !== 1'b1 && cyc < 100) begin
        stall = ($urandom_range(0, 3) == 0);
        tick();
        cyc++;
        if (irq_ack !== 3'b000) begin
          n_tests++; if (irq_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack%0d: got %0b expected %0b", n, irq_ack, exp_ack); end
          exp_ack = 3'b000;
        end
      end
      stall = 0;
      n_tests++; if (bus.instr_valid !== 1'b1 || exp_ack !== 3'b000) begin
        n_fail++; $display("FAIL rnd_wait%0d: valid %0b outstanding ack %0b expected 1/0", n, bus.instr_valid, exp_ack);
      end
      n_tests++; if (bus.opcode !== op || bus.operand_count !== 2'(cnt) || bus.operands !== {m_ops[2], m_ops[1], m_ops[0]} || bus.addr_bus !== m_next) begin
        n_fail++; $display("FAIL rnd_instr%0d: opcode %0h count %0d operands %0h pc %0h expected %0h/%0d/%0h/%0h", n,
                            bus.opcode, bus.operand_count, bus.operands, bus.addr_bus, op, cnt, {m_ops[2], m_ops[1], m_ops[0]}, m_next);
      end
      n_tests++; if (irq_active !== m_active || ret_pc !== m_ret) begin
        n_fail++; $display("FAIL rnd_irqstate%0d: active %0b ret_pc %0h expected %0b/%0h", n, irq_active, ret_pc, m_active, m_ret);
      end
      for (int w = $urandom_range(0, 2); w > 0; w--) begin
        stall = $urandom_range(0, 1);
        tick();
        n_tests++; if (bus.instr_valid !== 1'b1 || bus.addr_bus !== m_next) begin
          n_fail++; $display("FAIL rnd_hold%0d: valid %0b pc %0h expected 1/%0h", n, bus.instr_valid, bus.addr_bus, m_next);
        end
      end
      br    = ($urandom_range(0, 3) == 0);
      done  = ($urandom_range(0, 5) == 0);
      tgt   = 12'($urandom_range(0, 4095));
      m_gie = ($urandom_range(0, 2) == 0);
      m_req = 3'($urandom_range(0, 7));
      m_en  = 3'($urandom_range(0, 7));
      bus.branch_valid = br; bus.branch_target = tgt; bus.irq_done = done;
      gie = m_gie; irq_req = m_req; irq_en = m_en;
      stall = $urandom_range(0, 1);
      bus.instr_ready = 1;
      tick();
      bus.instr_ready = 0; bus.branch_valid = 0; bus.irq_done = 0;
      if (done) begin m_pc = m_ret; m_active = 0; end
      else if (br) m_pc = tgt;
      else m_pc = m_next;
      n_tests++; if (bus.addr_bus !== m_pc || bus.instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL rnd_redirect%0d: pc %0h valid %0b expected %0h/0", n, bus.addr_bus, bus.instr_valid, m_pc);
      end
      if (m_gie && (m_req & m_en) != 3'b000 && !m_active) begin
        k = 0;
        while (!(m_req[k] && m_en[k])) k++;
        exp_ack  = 3'b001 << k;
        m_ret    = m_pc;
        m_pc     = 12'h010 + 12'(k * 16);
        m_active = 1;
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1;
    clear_inputs();
    test_reset();
    test_single();
    test_operands_backpressure();
    test_irq();
    test_wrap_and_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
